// File: rtl/sccb_config_sequencer.sv
// Camera register programming sequencer: walks a synchronous config ROM and
// issues each {reg_addr, reg_data} entry as one SCCB write, with delay/end commands.
module sccb_config_sequencer #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int ROM_AW     = 8,
  parameter int POWERUP_MS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ready,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [ROM_AW:0]   write_count,
  output logic [3:0]        dbg_state
);

  localparam logic [31:0] CYCLES_PER_MS = 32'(CLK_FREQ / 1000);
  localparam logic [31:0] PWRUP_TOTAL   = 32'(POWERUP_MS) * CYCLES_PER_MS;
  localparam logic [31:0] PWRUP_LOAD    = (PWRUP_TOTAL == 32'd0) ? 32'd0 : PWRUP_TOTAL - 32'd1;
  localparam logic [ROM_AW-1:0] ROM_LAST = {ROM_AW{1'b1}};
  localparam logic [ROM_AW:0]   WC_MAX   = {1'b1, {ROM_AW{1'b0}}};

  typedef enum logic [3:0] {
    PWRUP     = 4'd0,
    FETCH     = 4'd1,
    LATCH     = 4'd2,
    DECODE    = 4'd3,
    SEND      = 4'd4,
    WAIT_ACK  = 4'd5,
    WAIT_DONE = 4'd6,
    DELAY     = 4'd7,
    NEXT      = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         entry_q, entry_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ROM_AW:0]     wc_q, wc_d;
  logic [31:0]         dly_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP;
      cnt_q      <= PWRUP_LOAD;
      rom_addr_q <= '0;
      entry_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      entry_q    <= entry_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wc_q       <= wc_d;
    end
  end

  // SCCB handshake: sccb_start is a one-cycle request raised only while
  // sccb_ready is high; the engine accepts it on that edge, drops ready the
  // next cycle and raises it again when the write has finished.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    entry_d    = entry_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wc_d       = wc_q;
    sccb_start = 1'b0;
    dly_prod   = {24'd0, entry_q[7:0]} * CYCLES_PER_MS;
    case (state_q)
      PWRUP: begin
        if (cnt_q == 32'd0) state_d = FETCH;
        else                cnt_d   = cnt_q - 32'd1;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        entry_d = rom_data;
        state_d = DECODE;
      end
      DECODE: begin
        if (entry_q == 16'hFFFF) begin
          state_d = DONE;
        end else if (entry_q[15:8] == 8'hFF) begin
          cnt_d   = (dly_prod == 32'd0) ? 32'd0 : dly_prod - 32'd1;
          state_d = DELAY;
        end else begin
          addr_d  = entry_q[15:8];
          data_d  = entry_q[7:0];
          state_d = SEND;
        end
      end
      SEND: begin
        if (sccb_ready) begin
          sccb_start = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!sccb_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sccb_ready) begin
          if (wc_q != WC_MAX) wc_d = wc_q + (ROM_AW+1)'(1);
          state_d = NEXT;
        end
      end
      DELAY: begin
        if (cnt_q == 32'd0) state_d = NEXT;
        else                cnt_d   = cnt_q - 32'd1;
      end
      NEXT: begin
        // A table without an end marker stops after its last slot.
        if (rom_addr_q == ROM_LAST) begin
          state_d = DONE;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = FETCH;
        end
      end
      DONE: begin
        if (cfg_start) begin
          rom_addr_d = '0;
          wc_d       = '0;
          state_d    = FETCH;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  assign rom_addr     = rom_addr_q;
  assign sccb_address = addr_q;
  assign sccb_data    = data_q;
  assign write_count  = wc_q;
  assign cfg_busy     = (state_q != DONE);
  assign cfg_done     = (state_q == DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer: 4-entry ROM, behavioural SCCB
// engine with configurable busy time, expected-write scoreboard.
module tb_sccb_config_sequencer;

  localparam int ROM_AW = 2;
  localparam logic [3:0] S_PWRUP = 4'd0, S_SEND = 4'd4, S_WAIT_DONE = 4'd6, S_DONE = 4'd9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_start;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              sccb_start;
  logic [7:0]        sccb_address;
  logic [7:0]        sccb_data;
  logic              sccb_ready;
  logic              cfg_busy;
  logic              cfg_done;
  logic [ROM_AW:0]   write_count;
  logic [3:0]        dbg_state;

  sccb_config_sequencer #(.CLK_FREQ(10_000), .ROM_AW(ROM_AW), .POWERUP_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_start(sccb_start), .sccb_address(sccb_address), .sccb_data(sccb_data),
    .sccb_ready(sccb_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .write_count(write_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM and SCCB engine models ----------------
  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          eng_lat = 50;
  logic        ready_block = 1'b0;
  logic        eng_idle = 1'b1;
  int          eng_cnt = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          stab_err = 0;
  logic [15:0] hold_word = '0;
  logic [15:0] got_q[$];
  int          start_cyc_q[$];

  assign sccb_ready = eng_idle && !ready_block;

  always @(posedge clk) begin
    if (sccb_start) start_cnt <= start_cnt + 1;
    if (sccb_start && sccb_ready) begin
      got_q.push_back({sccb_address, sccb_data});
      start_cyc_q.push_back(cyc);
      hold_word <= {sccb_address, sccb_data};
      eng_idle  <= 1'b0;
      eng_cnt   <= eng_lat;
    end else if (!eng_idle) begin
      if (rst_n && ({sccb_address, sccb_data} !== hold_word)) stab_err <= stab_err + 1;
      if (eng_cnt <= 1) eng_idle <= 1'b1;
      else              eng_cnt  <= eng_cnt - 1;
    end
    cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic check_writes(input int base, input string tag);
    check({tag, "_nwrites"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) check($sformatf("%s_write%0d", tag, i), 32'(got_q[base+i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},    32'(dbg_state),    32'(S_PWRUP));
    check({tag, "_rom_addr"}, 32'(rom_addr),     32'd0);
    check({tag, "_start"},    32'(sccb_start),   32'd0);
    check({tag, "_address"},  32'(sccb_address), 32'd0);
    check({tag, "_data"},     32'(sccb_data),    32'd0);
    check({tag, "_busy"},     32'(cfg_busy),     32'd1);
    check({tag, "_done"},     32'(cfg_done),     32'd0);
    check({tag, "_wcount"},   32'(write_count),  32'd0);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(dbg_state == st), 32'd1);
  endtask

  task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic restart(output int e);
    @(negedge clk);
    cfg_start = 1'b1;
    e = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int rel, e, base, sbase, u;

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Power-up run; a cfg_start pulse while busy must be ignored.
    rst_n = 1'b1;
    rel = cyc;
    base = got_q.size();
    sbase = start_cnt;
    repeat (5) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_state(S_DONE, 2000, "t1");
    check("t1_first_start_cyc", 32'(start_cyc_q[base] - rel), 32'd23);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
    check_writes(base, "t1");
    check("t1_done",     32'(cfg_done),    32'd1);
    check("t1_busy",     32'(cfg_busy),    32'd0);
    check("t1_wcount",   32'(write_count), 32'd2);
    check("t1_starts",   32'(start_cnt - sbase), 32'd2);
    check("t1_rom_addr", 32'(rom_addr),    32'd2);

    // Restart with a 3 ms delay entry; busy-time cfg_start is ignored.
    load_rom(16'hFF03, 16'h3A04, 16'hFFFF, 16'h0000);
    base = got_q.size();
    sbase = start_cnt;
    restart(e);
    check("t2_busy",     32'(cfg_busy),    32'd1);
    check("t2_done",     32'(cfg_done),    32'd0);
    check("t2_rom_addr", 32'(rom_addr),    32'd0);
    check("t2_wcount",   32'(write_count), 32'd0);
    repeat (8) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_state(S_DONE, 2000, "t2");
    check("t2_delay_gap", 32'(start_cyc_q[base] - (e + 3)), 32'd35);
    exp_q.push_back(16'h3A04);
    check_writes(base, "t2");
    check("t2_wcount_end", 32'(write_count), 32'd1);
    check("t2_starts",     32'(start_cnt - sbase), 32'd1);

    // Table with no end marker: every slot written, then DONE.
    load_rom(16'h4010, 16'h4010, 16'h4010, 16'h4010);
    base = got_q.size();
    restart(e);
    wait_state(S_DONE, 3000, "t3");
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h4010);
    check_writes(base, "t3");
    check("t3_rom_addr", 32'(rom_addr),    32'd3);
    check("t3_wcount",   32'(write_count), 32'd4);

    // Engine not ready for 100 cycles: request must wait for ready.
    load_rom(16'h5566, 16'hFFFF, 16'h0000, 16'h0000);
    base = got_q.size();
    sbase = start_cnt;
    ready_block = 1'b1;
    restart(e);
    repeat (100) @(negedge clk);
    check("t4_no_start",  32'(start_cnt - sbase), 32'd0);
    check("t4_state",     32'(dbg_state),    32'(S_SEND));
    check("t4_address",   32'(sccb_address), 32'h55);
    check("t4_data",      32'(sccb_data),    32'h66);
    ready_block = 1'b0;
    u = cyc;
    wait_state(S_DONE, 2000, "t4");
    check("t4_start_cyc", 32'(start_cyc_q[base]), 32'(u));
    check("t4_starts",    32'(start_cnt - sbase), 32'd1);
    exp_q.push_back(16'h5566);
    check_writes(base, "t4");

    // Reset in the middle of a write, then full power-up replay.
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    restart(e);
    wait_state(S_WAIT_DONE, 200, "t5_wd");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    u = 0;
    while (!sccb_ready && u < 200) begin
      @(negedge clk);
      u++;
    end
    check("t5_engine_idle", 32'(sccb_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    base = got_q.size();
    wait_state(S_DONE, 2000, "t5");
    if (got_q.size() > base) check("t5_first_start_cyc", 32'(start_cyc_q[base] - rel), 32'd23);
    else                     check("t5_first_start_seen", 32'(got_q.size() - base), 32'd1);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
    check_writes(base, "t5");
    check("t5_wcount", 32'(write_count), 32'd2);

    // Every pulse was a single accepted request, data held throughout.
    check("all_starts_accepted", 32'(start_cnt), 32'(got_q.size()));
    check("all_stable",          32'(stab_err),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
